// File: rtl/ntt_pkg.sv
// -----------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT coefficient-bank stream controller:
//   - default geometry of one coefficient bank (data width, address width, depth)
//   - controller state encoding
//   - bitrev(): reverses the bit order of a bank address. The load path uses it
//     when the NTT_BITREV_LOAD_EN build option is defined.
// -----------------------------------------------------------------------------
package ntt_pkg;

  localparam int NTT_DW    = 18;
  localparam int NTT_AW    = 8;
  localparam int NTT_DEPTH = 1 << NTT_AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FULL   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  function automatic logic [NTT_AW-1:0] bitrev(input logic [NTT_AW-1:0] a);
    logic [NTT_AW-1:0] r;
    r = '0;
    for (int b = 0; b < NTT_AW; b++) begin
      r[b] = a[NTT_AW-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_skid_fifo2.sv
// -----------------------------------------------------------------------------
// ntt_skid_fifo2
// Two-entry FIFO that absorbs words returning from the bank read port, so the
// outbound stream can stall without losing a read that is already in flight.
// The controller never pushes when the FIFO is full and never pops it when it
// is empty; a pop on an empty FIFO is ignored anyway.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   i_flush      in   synchronous flush (empties the FIFO)
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   DW  data to write
//   i_pop        in   drop the head entry
//   o_head       out  DW  head entry (valid when o_occ != 0)
//   o_occ        out  2   number of stored entries (0..2)
// -----------------------------------------------------------------------------
module ntt_skid_fifo2
  import ntt_pkg::*;
#(
  parameter int DW = NTT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;
  logic          w_pop;

  assign w_pop = i_pop && (r_occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      // NOTE: the two storage words are reset as well, because the head
      // drives the outbound data port directly and it must read 0 out of reset.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/ntt_bram_stream_ctrl.sv
// -----------------------------------------------------------------------------
// ntt_bram_stream_ctrl
// Load/unload controller for one DEPTH x DW NTT coefficient bank.
//   IDLE --load_start--> LOAD --last beat--> FULL --unload_start--> UNLOAD
//   UNLOAD --last outbound beat--> IDLE
// LOAD writes an inbound valid/ready stream into the bank. UNLOAD reads the
// bank back in natural order and streams it out with full backpressure; the
// bank's one-cycle read latency is hidden behind a 2-entry skid FIFO.
// Build option: NTT_BITREV_LOAD_EN -- when defined, load writes land at the
// bit-reversed address so the in-place NTT sees bit-reversed input order.
// DEPTH must equal 1<<AW.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   load_start / unload_start      start requests (LOAD from IDLE / UNLOAD from FULL)
//   s_data, s_valid, s_ready       inbound coefficient stream
//   m_data, m_valid, m_ready       outbound coefficient stream
//   m_last                         marks the outbound beat of coefficient DEPTH-1
//   load_done                      1-cycle pulse on entry to FULL
//   busy                           high in LOAD and UNLOAD
//   bram_wr_en/addr/din            bank write port
//   bram_rd_addr, bram_rd_dout     bank read port (data valid one cycle later)
// -----------------------------------------------------------------------------
module ntt_bram_stream_ctrl
  import ntt_pkg::*;
#(
  parameter int DW    = NTT_DW,
  parameter int AW    = NTT_AW,
  parameter int DEPTH = NTT_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          unload_start,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          load_done,
  output logic          busy,
  output logic          bram_wr_en,
  output logic [AW-1:0] bram_wr_addr,
  output logic [DW-1:0] bram_wr_din,
  output logic [AW-1:0] bram_rd_addr,
  input  logic [DW-1:0] bram_rd_dout
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_LAST  = (AW+1)'(DEPTH - 1);

  state_t      r_state;
  logic [AW:0] r_ld_cnt;
  logic [AW:0] r_rd_cnt;
  logic [AW:0] r_out_cnt;
  logic        r_inflight;
  logic        r_load_done;

  logic        w_accept;
  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_room_used;
  logic [1:0]  w_fifo_occ;
  logic        w_flush;

  assign w_accept = s_valid && (r_state == LOAD);
  assign w_pop    = m_valid && m_ready;

  // A read may issue only if, after this cycle's pop, the FIFO plus the word
  // still in flight from the bank leave room for one more returning word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // this block leaves it unassigned (which would infer a latch).
    w_room_used = 3'd0;
    w_issue     = 1'b0;
    if (r_state == UNLOAD) begin
      w_room_used = {1'b0, w_fifo_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue     = (r_rd_cnt < LP_DEPTH) && (w_room_used < 3'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ld_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values; a later assignment in this block overrides an
      // earlier one (used below to clear counters on state exit).
      r_load_done <= 1'b0;
      r_inflight  <= w_issue;
      if (w_issue) r_rd_cnt  <= r_rd_cnt + 1'b1;
      if (w_pop)   r_out_cnt <= r_out_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          r_ld_cnt <= '0;
          if (load_start) r_state <= LOAD;
        end
        LOAD: begin
          if (w_accept) begin
            if (r_ld_cnt == LP_LAST) begin
              r_state     <= FULL;
              r_ld_cnt    <= '0;
              r_load_done <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (unload_start) begin
            r_state   <= UNLOAD;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        UNLOAD: begin
          if (w_pop && m_last) begin
            r_state   <= IDLE;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Start every unload from an empty FIFO.
  assign w_flush = (r_state == FULL) && unload_start;

  ntt_skid_fifo2 #(.DW(DW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (r_inflight),
    .i_push_data (bram_rd_dout),
    .i_pop       (w_pop),
    .o_head      (m_data),
    .o_occ       (w_fifo_occ)
  );

  assign m_valid = (w_fifo_occ != 2'd0);
  assign m_last  = m_valid && (r_out_cnt == LP_LAST);

  assign s_ready   = (r_state == LOAD);
  assign busy      = (r_state == LOAD) || (r_state == UNLOAD);
  assign load_done = r_load_done;

  assign bram_wr_en  = w_accept;
  assign bram_wr_din = s_data;
`ifdef NTT_BITREV_LOAD_EN
  assign bram_wr_addr = bitrev(r_ld_cnt[AW-1:0]);
`else
  assign bram_wr_addr = r_ld_cnt[AW-1:0];
`endif
  assign bram_rd_addr = r_rd_cnt[AW-1:0];

endmodule

// File: tb/tb_ntt_bram_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ntt_bram_stream_ctrl
// Directed bench for ntt_bram_stream_ctrl paired with a 256x18 bank model that
// has a registered read address. A reference model follows the controller at
// the level of transactions (mode, beats loaded, beats delivered, expected bank
// contents) and is compared against the DUT every cycle; directed sequences add
// hand-computed expectations for latency, ordering and boundary behaviour.
// Build with +define+NTT_BITREV_LOAD_EN to exercise the bit-reversed load.
// -----------------------------------------------------------------------------
module tb_ntt_bram_stream_ctrl;

  localparam int DW = 18;
  localparam int AW = 8;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, unload_start;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last;
  logic          load_done, busy;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr, bram_rd_addr;
  logic [DW-1:0] bram_wr_din, bram_rd_dout;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ld_pulses = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_bram_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .unload_start(unload_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .load_done(load_done), .busy(busy),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_din(bram_wr_din),
    .bram_rd_addr(bram_rd_addr), .bram_rd_dout(bram_rd_dout)
  );

  // Bank model: synchronous write, registered read address.
  logic [DW-1:0] bank [N];
  logic [AW-1:0] rd_q;
  always @(posedge clk) begin
    if (bram_wr_en) bank[bram_wr_addr] <= bram_wr_din;
    rd_q <= bram_rd_addr;
  end
  assign bram_rd_dout = bank[rd_q];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] a);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = a[7-b];
    return r;
  endfunction

  // Bank address that load beat i is written to.
  function automatic int wr_map(input int i);
`ifdef NTT_BITREV_LOAD_EN
    return int'(rev8(8'(i)));
`else
    return i;
`endif
  endfunction

  function automatic logic [DW-1:0] dfun(input int kind, input int i);
    logic [31:0] t;
    case (kind)
      0:       t = 32'(i);
      1:       t = (32'(i) * 32'd1031 + 32'd7) & 32'h3FFFF;
      default: t = 32'h3FFFF - 32'(i);
    endcase
    return t[DW-1:0];
  endfunction

  // Value expected at outbound position k after a full load of data kind `kind`:
  // the natural-order unload returns bank[k], which holds the beat whose write
  // address was k.
  function automatic logic [DW-1:0] out_exp(input int kind, input int k);
`ifdef NTT_BITREV_LOAD_EN
    return dfun(kind, int'(rev8(8'(k))));
`else
    return dfun(kind, k);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference model and per-cycle compare.
  // md_mode: 0 idle, 1 load, 2 full, 3 unload.
  // ---------------------------------------------------------------------------
  int            md_mode = 0;
  int            md_ld = 0;
  int            md_out = 0;
  bit            md_done_due = 1'b0;
  logic [DW-1:0] md_bank [N];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", 32'(s_ready), 32'(md_mode == 1));
      check("busy", 32'(busy), 32'(md_mode == 1 || md_mode == 3));
      check("load_done", 32'(load_done), 32'(md_done_due));
      check("wr_en", 32'(bram_wr_en), 32'(md_mode == 1 && s_valid));
      if (md_mode == 1 && s_valid) begin
        check("wr_addr", 32'(bram_wr_addr), 32'(wr_map(md_ld)));
        check("wr_din", 32'(bram_wr_din), 32'(s_data));
      end
      if (md_mode != 3) check("m_valid_off", 32'(m_valid), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (load_done) ld_pulses++;

      md_done_due = 1'b0;
      if (rst) begin
        md_mode = 0; md_ld = 0; md_out = 0;
      end else begin
        case (md_mode)
          0: if (load_start) md_mode = 1;
          1: if (s_valid) begin
               md_bank[wr_map(md_ld)] = s_data;
               md_ld++;
               if (md_ld == N) begin md_mode = 2; md_ld = 0; md_done_due = 1'b1; end
             end
          2: if (unload_start) md_mode = 3;
          default: if (m_valid && m_ready) begin
               check("model_data", 32'(m_data), 32'(md_bank[md_out]));
               check("model_last", 32'(m_last), 32'(md_out == N - 1));
               md_out++;
               if (md_out == N) begin md_mode = 0; md_out = 0; end
             end
        endcase
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data  = m_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers. Inputs change 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input bit ld, input bit ul);
    @(posedge clk); #1;
    load_start = ld; unload_start = ul;
    @(posedge clk); #1;
    load_start = 1'b0; unload_start = 1'b0;
  endtask

  // Called 1 ns after the edge on which LOAD was entered; returns 1 ns after
  // the edge that accepted beat n-1.
  task automatic load_beats(input int n, input int kind, input bit gaps);
    int idx = 0;
    int it = 0;
    while (idx < n && it < 2000) begin
      s_valid = gaps ? (it % 3 != 1) : 1'b1;
      s_data  = dfun(kind, idx);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      it++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    check("load_beat_count", 32'(idx), 32'(n));
  endtask

  // rpat: 0 = m_ready held high, 1 = 1,0,0,1 repeating, 2 = low every 5th cycle.
  task automatic unload_run(input int kind, input int rpat);
    logic [DW-1:0] rx [N];
    bit            lx [N];
    int            nrx = 0;
    int            it = 0;
    int            t0, first_c, last_c;
    bit            seen = 1'b0;
    first_c = 0; last_c = 0;
    @(posedge clk); #1;
    unload_start = 1'b1;
    t0 = cyc;
    while (nrx < N && it < 3000) begin
      @(posedge clk); #1;
      unload_start = 1'b0;
      case (rpat)
        0:       m_ready = 1'b1;
        1:       m_ready = (it % 4 == 0) || (it % 4 == 3);
        default: m_ready = (it % 5 != 2);
      endcase
      it++;
      @(negedge clk);
      if (m_valid && !seen) begin seen = 1'b1; first_c = cyc; end
      if (m_valid && m_ready) begin
        rx[nrx] = m_data; lx[nrx] = m_last; last_c = cyc; nrx++;
      end
    end
    check("unload_beat_count", 32'(nrx), 32'(N));
    for (int k = 0; k < nrx; k++) begin
      check("unload_data", 32'(rx[k]), 32'(out_exp(kind, k)));
      check("unload_last", 32'(lx[k]), 32'(k == N - 1));
    end
    if (rpat == 0) begin
      check("first_valid_latency", 32'(first_c - t0), 32'd3);
      check("burst_span", 32'(last_c - first_c), 32'(N - 1));
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("idle_after_unload_busy", 32'(busy), 32'd0);
    check("idle_after_unload_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; unload_start = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_wr_en", 32'(bram_wr_en), 32'd0);
    check("rst_rd_addr", 32'(bram_rd_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // unload_start in IDLE is ignored.
    pulse_start(1'b0, 1'b1);
    check("ign_unload_s_ready", 32'(s_ready), 32'd0);
    check("ign_unload_busy", 32'(busy), 32'd0);

    // Load 0..255 with s_valid held high.
    pulse_start(1'b1, 1'b0);
    check("load_entered", 32'(s_ready), 32'd1);
    load_beats(N, 0, 1'b0);
    @(negedge clk);
    check("load_done_after_last", 32'(load_done), 32'd1);
    check("full_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("load_done_one_cycle", 32'(load_done), 32'd0);
`ifdef NTT_BITREV_LOAD_EN
    check("bank_0x80_beat1", 32'(bank[8'h80]), 32'd1);
    check("bank_0x60_beat6", 32'(bank[8'h60]), 32'd6);
`else
    check("bank_1_beat1", 32'(bank[1]), 32'd1);
    check("bank_6_beat6", 32'(bank[6]), 32'd6);
    check("bank_255_beat255", 32'(bank[255]), 32'd255);
`endif

    // load_start in FULL is ignored.
    pulse_start(1'b1, 1'b0);
    check("ign_load_s_ready", 32'(s_ready), 32'd0);
    check("ign_load_busy", 32'(busy), 32'd0);

    // Unload with m_ready held high.
    unload_run(0, 0);

    // Both starts in IDLE: load wins. Then unload with m_ready 1,0,0,1.
    pulse_start(1'b1, 1'b1);
    check("both_starts_load", 32'(s_ready), 32'd1);
    load_beats(N, 1, 1'b0);
    unload_run(1, 1);

    // Abort a load after 100 beats with reset.
    pulse_start(1'b1, 1'b0);
    load_beats(100, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_s_ready", 32'(s_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_no_load_done", 32'(load_done), 32'd0);

    // Reload with gaps on s_valid, unload with periodic stalls.
    pulse_start(1'b1, 1'b0);
    load_beats(N, 2, 1'b1);
    unload_run(2, 2);

    check("load_done_total", 32'(ld_pulses), 32'd3);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
